// File: rtl/top_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, the frame
// width, and the 2-of-3 vote used by the bit sampler.
package top_rx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receiver. It only decides which part of the
// frame is on the wire; all counting, sampling and checking lives in top_rx.
module uart_rx_fsm
  import top_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       edge_last,
  input  logic       bit_last,
  input  logic       samp_bit,
  input  logic       par_en,
  output logic [2:0] state
);

  logic [2:0] curr_state, next_state;

  // next-state decode; every bit-phase change happens on the last edge count
  always_comb begin
    next_state = curr_state;
    case (curr_state)
      IDLE:    if (!rx_in) next_state = START;
      // a start bit that votes high was a glitch: go back and wait
      START:   if (edge_last) next_state = samp_bit ? IDLE : DATA;
      DATA:    if (edge_last && bit_last) next_state = par_en ? PARITY : STOP;
      PARITY:  if (edge_last) next_state = STOP;
      STOP:    if (edge_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) curr_state <= IDLE;
    else      curr_state <= next_state;
  end

  assign state = curr_state;

endmodule

// File: rtl/top_rx.sv
// UART receiver: oversampled by prescale (8/16/32), 3-sample majority vote
// per bit, optional even/odd parity, one stop bit. P_DATA holds the last good
// byte; data_valid pulses once on the first IDLE cycle after a clean frame.
module top_rx
  import top_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic [2:0]            state;
  logic [5:0]            presc_q, edge_cnt, half;
  logic                  par_en_q, par_typ_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [1:0]            samp;
  logic                  samp_bit, samp_done, maj, edge_last, bit_last;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err, stp_err;

  assign half      = {1'b0, presc_q[5:1]};
  assign edge_last = (edge_cnt == presc_q - 6'd1);
  // the third sample is taken live from RX_IN on this count
  assign samp_done = (edge_cnt == half + 6'd1);
  assign maj       = maj3(samp[0], samp[1], RX_IN);
  assign bit_last  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  uart_rx_fsm FSM (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (RX_IN),
    .edge_last (edge_last),
    .bit_last  (bit_last),
    .samp_bit  (samp_bit),
    .par_en    (par_en_q),
    .state     (state)
  );

  // frame configuration is frozen for the whole frame, reloaded only in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (state == IDLE) begin
      presc_q   <= prescale;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  // edge counter: 0..prescale-1 inside each bit, parked at 0 while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             edge_cnt <= '0;
    else if (state == IDLE || edge_last)  edge_cnt <= '0;
    else                                  edge_cnt <= edge_cnt + 6'd1;
  end

  // data bit counter, advances at the end of each data bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                bit_cnt <= '0;
    else if (state != DATA)  bit_cnt <= '0;
    else if (edge_last)      bit_cnt <= bit_cnt + 1'b1;
  end

  // sampler: capture mid-1 and mid, vote with mid+1, hold the voted bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp     <= '0;
      samp_bit <= 1'b0;
    end else begin
      if (edge_cnt == half - 6'd1) samp[0]  <= RX_IN;
      if (edge_cnt == half)        samp[1]  <= RX_IN;
      if (samp_done)               samp_bit <= maj;
    end
  end

  // deserializer: LSB arrives first, so shift in from the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            shreg <= '0;
    else if (state == DATA && samp_done) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
  end

  // parity and stop checkers; flags clear as a new frame begins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (state == IDLE && !RX_IN) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (samp_done) begin
      if (state == PARITY) par_err <= (maj != (^shreg ^ par_typ_q));
      if (state == STOP)   stp_err <= ~maj;
    end
  end

  // output register: publish the byte on a clean STOP->IDLE transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == STOP) && edge_last && !par_err && !stp_err;
      if ((state == STOP) && edge_last && !par_err && !stp_err) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_top_rx.sv
// Bench for top_rx: directed frames from the requirement list followed by
// randomized frames. A frame-level model decides which frames are clean and
// queues their bytes; a cycle monitor checks every data_valid pulse and that
// P_DATA only ever changes to the next expected byte.
module tb_top_rx;
  import top_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b1;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_spur = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       dv_prev = 1'b0;

  top_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (prescale) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // frame-level reference: a frame is good iff the stop bit is 1 and, when
  // parity is enabled, the total number of ones in data+parity is even
  // (PAR_TYP=0) or odd (PAR_TYP=1)
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    int  ones;
    logic ok;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(pbit);
    ok = stop && (!PAR_EN || ((ones % 2) == int'(PAR_TYP)));
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(pbit);
    if (ok) exp_q.push_back(d);
    drive_bit(stop);
  endtask

  // cycle monitor
  always @(negedge clk) begin
    if (!rst) begin
      last_good = 8'h00;
      dv_prev   = 1'b0;
    end else begin
      if (data_valid) begin
        chk("dv_one_cycle", dv_prev, 1'b0);
        chk("dv_in_idle", dut.FSM.curr_state, IDLE);
        if (exp_q.size() != 0) last_good = exp_q.pop_front();
        else n_spur++;
      end
      chk("p_data", P_DATA, last_good);
      dv_prev = data_valid;
    end
  end

  initial begin
    logic [7:0] aa;
    logic [7:0] d;
    logic       pbit, stop;
    int         gap;
    logic       prev_gap0;

    repeat (3) @(negedge clk);
    chk("rst_p_data", P_DATA, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_state", dut.FSM.curr_state, IDLE);
    rst = 1'b1;
    idle_bits(2);

    // glitchy start bit: 2 clocks low, then high; then 8'hAA follows
    prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    aa = 8'hAA;
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (6) @(negedge clk);
    RX_IN = aa[0];
    @(negedge clk);
    chk("glitch_idle", dut.FSM.curr_state, IDLE);
    repeat (7) @(negedge clk);
    for (int i = 1; i < 8; i++) drive_bit(aa[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle_bits(3);
    chk("glitch_p_data", P_DATA, 8'h00);

    // parity error, even parity, 8'hAA with parity bit 1
    send_frame(8'hAA, 1'b1, 1'b1);
    idle_bits(2);
    chk("perr_p_data", P_DATA, 8'h00);

    // prescale 16, even parity, 8'hF0
    prescale = 6'd16;
    send_frame(8'hF0, 1'b0, 1'b1);
    idle_bits(2);
    chk("p16_drained", exp_q.size(), 0);
    chk("p16_p_data", P_DATA, 8'hF0);

    // prescale 32, even parity, 8'h0F
    prescale = 6'd32;
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_bits(2);
    chk("p32_drained", exp_q.size(), 0);
    chk("p32_p_data", P_DATA, 8'h0F);

    // stop error, no parity
    prescale = 6'd8; PAR_EN = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0);
    idle_bits(2);
    chk("stperr_p_data", P_DATA, 8'h0F);

    // odd parity, 8'h01 with parity bit 0
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(2);
    chk("odd_drained", exp_q.size(), 0);
    chk("odd_p_data", P_DATA, 8'h01);

    // reset in the middle of the data bits
    PAR_TYP = 1'b0;
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    RX_IN = d[3];
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state", dut.FSM.curr_state, IDLE);
    chk("midrst_p_data", P_DATA, 8'h00);
    chk("midrst_dv", data_valid, 1'b0);
    RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_bits(1);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_bits(2);
    chk("postrst_drained", exp_q.size(), 0);
    chk("postrst_p_data", P_DATA, 8'hC3);

    // randomized frames, occasionally back-to-back
    prev_gap0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: prescale = 6'd8;
        1: prescale = 6'd16;
        default: prescale = 6'd32;
      endcase
      PAR_EN  = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      d       = 8'($urandom);
      pbit    = (PAR_TYP ? ~^d : ^d) ^ ($urandom_range(0, 5) == 0);
      stop    = ($urandom_range(0, 7) != 0);
      send_frame(d, pbit, stop);
      gap = prev_gap0 ? $urandom_range(1, 2) : $urandom_range(0, 2);
      prev_gap0 = (gap == 0);
      idle_bits(gap);
    end
    idle_bits(3);

    chk("final_drained", exp_q.size(), 0);
    chk("spurious_dv", n_spur, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
